// File: rtl/alu_pkg.sv
// Shared ALU widths, opcodes, held-entry layout and immediate extension.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_N  = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLT  = 3'b100,
        ALU_PASS = 3'b101
    } alu_op_e;

    // One instruction as presented to the ALU, plus the source tags needed to refresh it while stalled.
    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [2:0]        alu_sel;
        logic [ADDR_W-1:0] rd_addr;
        logic              rd_we;
        logic [ADDR_W-1:0] rs_addr;
        logic [ADDR_W-1:0] rt_addr;
        logic              use_imm;
    } entry_t;

    function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic [2:0] op);
        logic [DATA_W-1:0] ext;
        if (op == ALU_AND || op == ALU_OR) begin
            ext = {{(DATA_W-16){1'b0}}, imm};
        end else begin
            ext = {{(DATA_W-16){imm[15]}}, imm};
        end
        return ext;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file, two asynchronous read ports and one write port; r0 reads 0.
// Latency: reads combinational, writes visible after the clock edge.
// Backpressure: none, a write is always taken.
module regfile_2r1w
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int REG_N  = alu_pkg::REG_N,
    parameter int ADDR_W = alu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra0,
    output logic [DATA_W-1:0] rd0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem_q [REG_N];
    logic [DATA_W-1:0] mem_d [REG_N];

    always_comb begin
        mem_d = mem_q;
        if (we && wa != '0) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd0 = (ra0 == '0) ? '0 : mem_q[ra0];
    assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];

endmodule

// File: rtl/id_ex_operand_stage.sv
// Operand fetch with EX/WB forwarding and immediate select, registered toward the ALU.
// Latency: 1 cycle from accept to out_valid; one instruction per cycle when out_ready holds.
// Backpressure: in_ready = !out_valid || out_ready; a stalled entry keeps refreshing its operands.
module id_ex_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int REG_N  = alu_pkg::REG_N,
    parameter int ADDR_W = alu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_we_in,
    input  logic [15:0]       imm16,
    input  logic              use_imm,
    input  logic [2:0]        alu_sel_in,
    input  logic              flush,
    input  logic              ex_fwd_en,
    input  logic [ADDR_W-1:0] ex_fwd_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] OP1,
    output logic [DATA_W-1:0] OP2,
    output logic [2:0]        ALUSel,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              rd_we_out
);

    logic              valid_q, valid_d;
    entry_t            entry_q, entry_d;
    logic [DATA_W-1:0] rf_rs_data, rf_rt_data;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              accept;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra0   (rs_addr),
        .rd0   (rf_rs_data),
        .ra1   (rt_addr),
        .rd1   (rf_rt_data),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // EX result beats WB; 'base' is the regfile value on issue or the held value while stalled.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] base,
        input logic              e_en,
        input logic [ADDR_W-1:0] e_addr,
        input logic [DATA_W-1:0] e_data,
        input logic              w_en,
        input logic [ADDR_W-1:0] w_addr,
        input logic [DATA_W-1:0] w_data
    );
        logic [DATA_W-1:0] val;
        val = base;
        if (addr == '0) begin
            val = '0;
        end else if (e_en && e_addr == addr) begin
            val = e_data;
        end else if (w_en && w_addr == addr) begin
            val = w_data;
        end
        return val;
    endfunction

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        rs_val = fwd_sel(rs_addr, rf_rs_data, ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                         wb_en, wb_addr, wb_data);
        rt_val = fwd_sel(rt_addr, rf_rt_data, ex_fwd_en, ex_fwd_addr, ex_fwd_data,
                         wb_en, wb_addr, wb_data);
    end

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush) begin
            valid_d       = 1'b0;
            entry_d.rd_we = 1'b0;
        end else if (accept) begin
            valid_d         = 1'b1;
            entry_d.op1     = rs_val;
            entry_d.op2     = use_imm ? ext_imm(imm16, alu_sel_in) : rt_val;
            entry_d.alu_sel = alu_sel_in;
            entry_d.rd_addr = rd_addr;
            entry_d.rd_we   = rd_we_in;
            entry_d.rs_addr = rs_addr;
            entry_d.rt_addr = rt_addr;
            entry_d.use_imm = use_imm;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            entry_d.op1 = fwd_sel(entry_q.rs_addr, entry_q.op1, ex_fwd_en, ex_fwd_addr,
                                  ex_fwd_data, wb_en, wb_addr, wb_data);
            if (!entry_q.use_imm) begin
                entry_d.op2 = fwd_sel(entry_q.rt_addr, entry_q.op2, ex_fwd_en, ex_fwd_addr,
                                      ex_fwd_data, wb_en, wb_addr, wb_data);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= 1'b0;
            entry_q         <= '0;
            entry_q.alu_sel <= ALU_PASS;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign out_valid   = valid_q;
    assign OP1         = entry_q.op1;
    assign OP2         = entry_q.op2;
    assign ALUSel      = entry_q.alu_sel;
    assign rd_addr_out = entry_q.rd_addr;
    assign rd_we_out   = entry_q.rd_we;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding, immediates, stall refresh, streaming, flush.
module tb_id_ex_operand_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        rd_we_in;
    logic [15:0] imm16;
    logic        use_imm;
    logic [2:0]  alu_sel_in;
    logic        flush;
    logic        ex_fwd_en;
    logic [4:0]  ex_fwd_addr;
    logic [31:0] ex_fwd_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] OP1, OP2;
    logic [2:0]  ALUSel;
    logic [4:0]  rd_addr_out;
    logic        rd_we_out;

    int checks = 0;
    int errors = 0;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .rd_we_in(rd_we_in),
        .imm16(imm16), .use_imm(use_imm), .alu_sel_in(alu_sel_in), .flush(flush),
        .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .OP1(OP1), .OP2(OP2),
        .ALUSel(ALUSel), .rd_addr_out(rd_addr_out), .rd_we_out(rd_we_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0; rd_we_in = 0;
        imm16 = 0; use_imm = 0; alu_sel_in = 3'b000; flush = 0;
        ex_fwd_en = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic we, input logic [15:0] imm, input logic ui,
                         input logic [2:0] sel);
        in_valid = 1; rs_addr = rs; rt_addr = rt; rd_addr = rd; rd_we_in = we;
        imm16 = imm; use_imm = ui; alu_sel_in = sel;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 0;
    endtask

    task automatic test_reset();
        rst_n = 1; out_ready = 1; idle();
        #1 rst_n = 0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (OP1 !== 32'h0 || OP2 !== 32'h0) begin errors++; $display("FAIL reset_ops got %h %h exp 0 0", OP1, OP2); end
        checks++; if (ALUSel !== 3'b101) begin errors++; $display("FAIL reset_alusel got %b exp 101", ALUSel); end
        checks++; if (rd_addr_out !== 5'd0 || rd_we_out !== 1'b0) begin errors++; $display("FAIL reset_rd got %0d %b exp 0 0", rd_addr_out, rd_we_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        #10 rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        wb_write(5'd3, 32'h0000_0010);
        issue(5'd3, 5'd0, 5'd4, 1'b1, 16'h0, 1'b0, 3'b000);
        tick();
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++; if (OP1 !== 32'h10 || OP2 !== 32'h0) begin errors++; $display("FAIL basic_ops got %h %h exp 00000010 00000000", OP1, OP2); end
        checks++; if (ALUSel !== 3'b000 || rd_addr_out !== 5'd4 || rd_we_out !== 1'b1) begin errors++; $display("FAIL basic_fields got %b %0d %b exp 000 4 1", ALUSel, rd_addr_out, rd_we_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got %b exp 0", out_valid); end
    endtask

    task automatic test_imm();
        issue(5'd0, 5'd0, 5'd1, 1'b1, 16'hFFFC, 1'b1, 3'b000);
        tick();
        checks++; if (OP2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_add_sext got %h exp FFFFFFFC", OP2); end
        issue(5'd0, 5'd0, 5'd1, 1'b1, 16'hFFFC, 1'b1, 3'b011);
        tick();
        checks++; if (OP2 !== 32'h0000_FFFC) begin errors++; $display("FAIL imm_or_zext got %h exp 0000FFFC", OP2); end
        issue(5'd0, 5'd0, 5'd1, 1'b1, 16'h8001, 1'b1, 3'b010);
        tick();
        checks++; if (OP2 !== 32'h0000_8001) begin errors++; $display("FAIL imm_and_zext got %h exp 00008001", OP2); end
        issue(5'd0, 5'd0, 5'd1, 1'b1, 16'h8001, 1'b1, 3'b100);
        tick();
        idle();
        checks++; if (OP2 !== 32'hFFFF_8001 || ALUSel !== 3'b100) begin errors++; $display("FAIL imm_slt_sext got %h %b exp FFFF8001 100", OP2, ALUSel); end
        tick();
    endtask

    task automatic test_forwarding();
        ex_fwd_en = 1; ex_fwd_addr = 5'd5; ex_fwd_data = 32'h0000_AAAA;
        wb_en = 1; wb_addr = 5'd5; wb_data = 32'h0000_5555;
        issue(5'd5, 5'd5, 5'd2, 1'b1, 16'h0, 1'b0, 3'b000);
        tick();
        idle();
        checks++; if (OP1 !== 32'h0000_AAAA || OP2 !== 32'h0000_AAAA) begin errors++; $display("FAIL fwd_ex_priority got %h %h exp 0000AAAA 0000AAAA", OP1, OP2); end
        wb_en = 1; wb_addr = 5'd0; wb_data = 32'h1234;
        ex_fwd_en = 1; ex_fwd_addr = 5'd0; ex_fwd_data = 32'h4321;
        issue(5'd0, 5'd0, 5'd2, 1'b1, 16'h0, 1'b0, 3'b000);
        tick();
        idle();
        checks++; if (OP1 !== 32'h0 || OP2 !== 32'h0) begin errors++; $display("FAIL fwd_r0 got %h %h exp 0 0", OP1, OP2); end
        wb_en = 1; wb_addr = 5'd6; wb_data = 32'h0000_0066;
        issue(5'd5, 5'd6, 5'd2, 1'b1, 16'h0, 1'b0, 3'b001);
        tick();
        idle();
        checks++; if (OP1 !== 32'h0000_5555 || OP2 !== 32'h0000_0066) begin errors++; $display("FAIL fwd_rf_and_wb got %h %h exp 00005555 00000066", OP1, OP2); end
        tick();
    endtask

    task automatic test_stall();
        wb_write(5'd7, 32'h1);
        out_ready = 0;
        issue(5'd7, 5'd7, 5'd8, 1'b1, 16'h0, 1'b0, 3'b000);
        tick();
        checks++; if (out_valid !== 1'b1 || OP1 !== 32'h1 || OP2 !== 32'h1) begin errors++; $display("FAIL stall_capture got %b %h %h exp 1 1 1", out_valid, OP1, OP2); end
        issue(5'd0, 5'd0, 5'd9, 1'b1, 16'h0022, 1'b1, 3'b001);
        wb_en = 1; wb_addr = 5'd7; wb_data = 32'h99;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
        tick();
        idle();
        checks++; if (OP1 !== 32'h99 || OP2 !== 32'h99) begin errors++; $display("FAIL stall_refresh got %h %h exp 99 99", OP1, OP2); end
        checks++; if (out_valid !== 1'b1 || ALUSel !== 3'b000 || rd_addr_out !== 5'd8) begin errors++; $display("FAIL stall_hold got %b %b %0d exp 1 000 8", out_valid, ALUSel, rd_addr_out); end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_consumed got %b exp 0", out_valid); end
        out_ready = 0;
        issue(5'd0, 5'd7, 5'd8, 1'b1, 16'h0005, 1'b1, 3'b000);
        tick();
        idle();
        ex_fwd_en = 1; ex_fwd_addr = 5'd7; ex_fwd_data = 32'h42;
        tick();
        idle();
        checks++; if (OP2 !== 32'h5 || OP1 !== 32'h0) begin errors++; $display("FAIL stall_imm_kept got %h %h exp 0 5", OP1, OP2); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] sels [4];
        sels[0] = 3'b000; sels[1] = 3'b001; sels[2] = 3'b110; sels[3] = 3'b111;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            issue(5'd0, 5'd0, 5'(i + 1), 1'b1, 16'h8000 | 16'(i + 1), 1'b1, sels[i]);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || OP2 !== (32'hFFFF_8000 | 32'(i + 1)) || ALUSel !== sels[i] || rd_addr_out !== 5'(i + 1)) begin
                errors++;
                $display("FAIL b2b_out[%0d] got %b %h %b %0d exp 1 %h %b %0d", i, out_valid, OP2, ALUSel, rd_addr_out, 32'hFFFF_8000 | 32'(i + 1), sels[i], i + 1);
            end
        end
        issue(5'd0, 5'd0, 5'd20, 1'b1, 16'h7, 1'b1, 3'b000);
        flush = 1;
        tick();
        idle();
        checks++; if (out_valid !== 1'b0 || rd_we_out !== 1'b0) begin errors++; $display("FAIL flush got %b %b exp 0 0", out_valid, rd_we_out); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        wb_write(5'd9, 32'h123);
        out_ready = 0;
        issue(5'd9, 5'd0, 5'd3, 1'b1, 16'h0, 1'b0, 3'b001);
        tick();
        idle();
        checks++; if (out_valid !== 1'b1 || OP1 !== 32'h123) begin errors++; $display("FAIL rst_stall_setup got %b %h exp 1 123", out_valid, OP1); end
        #3 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || ALUSel !== 3'b101 || OP1 !== 32'h0) begin errors++; $display("FAIL rst_async got %b %b %h exp 0 101 0", out_valid, ALUSel, OP1); end
        #2 rst_n = 1;
        out_ready = 1;
        issue(5'd9, 5'd7, 5'd1, 1'b0, 16'h0, 1'b0, 3'b101);
        tick();
        idle();
        checks++; if (OP1 !== 32'h0 || OP2 !== 32'h0 || ALUSel !== 3'b101) begin errors++; $display("FAIL rst_cleared_rf got %h %h %b exp 0 0 101", OP1, OP2, ALUSel); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm();
        test_forwarding();
        test_stall();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
